rf_context_unit: RTL and testbench

- Context save/restore sequencer for the SAYEH CPU. It is the initiator side of the register file port set: it drives left/right read addresses, write data and the byte-lane write strobes.
- Save: reads all general registers in pairs, using both read ports at once, and stores them to a data-memory block starting at base_addr.
- Restore: loads the block back from memory and rewrites the registers, either as whole words or as low-byte then high-byte.
- Used for interrupt entry/exit and debugger context dumps.

---
 rtl/sayeh_pkg.sv | 20 ++
 rtl/rf_context_unit.sv | 180 ++++++++++++++++++
 tb/tb_rf_context_unit.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sayeh_pkg.sv
// Shared definitions for the SAYEH register-file context unit.
// Holds the sequencer state encoding and the default datapath widths.
package sayeh_pkg;

    localparam int DW_DEFAULT     = 16;
    localparam int REG_AW_DEFAULT = 2;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        S_RD  = 4'd1,
        S_WR0 = 4'd2,
        S_WR1 = 4'd3,
        R_LD  = 4'd4,
        R_WR  = 4'd5,
        R_WRL = 4'd6,
        R_WRH = 4'd7,
        DONE  = 4'd8
    } ctx_state_e;

endpackage

// File: rtl/rf_context_unit.sv
// rf_context_unit: context save/restore sequencer for the SAYEH register file.
//
// Save reads the general registers two at a time (left and right read ports)
// and writes them to a memory block at base_addr. Restore reads the block back
// and rewrites the registers, either as whole words or as a low-byte write
// followed by a high-byte write (RESTORE_SPLIT=1).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   save_req, restore_req    start requests, sampled only in IDLE (save wins)
//   base_addr                memory block base, latched on acceptance
//   busy, done               operation in progress / one-cycle completion pulse
//   rf_laddr, rf_raddr       register file left (also write) / right address
//   rf_lout, rf_rout         register file read data
//   rf_in, rf_lwrite, rf_hwrite  register file write data and byte strobes
//   mem_addr, mem_wdata      memory address / write data
//   mem_wr, mem_rd           memory write / read request
//   mem_rdata, mem_ready     memory read data / request accepted this cycle
//
// Memory handshake: mem_wr or mem_rd acts as the valid and is held, together
// with mem_addr and mem_wdata, unchanged until a cycle with mem_ready=1; the
// transfer completes at the rising edge ending that cycle, and mem_rdata is
// taken in that same cycle. mem_rd and mem_wr are never asserted together.
module rf_context_unit
    import sayeh_pkg::*;
#(
    parameter int NUM_REGS      = 4,
    parameter int REG_AW        = REG_AW_DEFAULT,
    parameter int DW            = DW_DEFAULT,
    parameter bit RESTORE_SPLIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              save_req,
    input  logic              restore_req,
    input  logic [DW-1:0]     base_addr,
    output logic              busy,
    output logic              done,
    output logic [REG_AW-1:0] rf_laddr,
    output logic [REG_AW-1:0] rf_raddr,
    input  logic [DW-1:0]     rf_lout,
    input  logic [DW-1:0]     rf_rout,
    output logic [DW-1:0]     rf_in,
    output logic              rf_lwrite,
    output logic              rf_hwrite,
    output logic [DW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DW-1:0]     mem_rdata,
    input  logic              mem_ready
);

    ctx_state_e        state_q, state_d;
    logic [REG_AW-1:0] idx_q, idx_d;     // save: even register 2p; restore: register i
    logic [DW-1:0]     base_q, base_d;
    logic [DW-1:0]     hold0_q, hold0_d;
    logic [DW-1:0]     hold1_q, hold1_d;

    logic [REG_AW-1:0] odd_idx;
    logic [DW-1:0]     idx_ext;
    logic [DW-1:0]     odd_ext;
    logic              last_pair;
    logic              last_reg;

    // In save mode idx_q is always even, so OR-ing in bit 0 gives 2p+1.
    assign odd_idx   = idx_q | REG_AW'(1);
    assign idx_ext   = {{(DW-REG_AW){1'b0}}, idx_q};
    assign odd_ext   = {{(DW-REG_AW){1'b0}}, odd_idx};
    assign last_pair = (idx_q == REG_AW'(NUM_REGS - 2));
    assign last_reg  = (idx_q == REG_AW'(NUM_REGS - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        base_d    = base_q;
        hold0_d   = hold0_q;
        hold1_d   = hold1_q;
        busy      = 1'b0;
        done      = 1'b0;
        rf_laddr  = '0;
        rf_raddr  = '0;
        rf_in     = '0;
        rf_lwrite = 1'b0;
        rf_hwrite = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;

        case (state_q)
            IDLE: begin
                if (save_req) begin
                    state_d = S_RD;
                    base_d  = base_addr;
                    idx_d   = '0;
                end else if (restore_req) begin
                    state_d = R_LD;
                    base_d  = base_addr;
                    idx_d   = '0;
                end
            end
            S_RD: begin
                busy     = 1'b1;
                rf_laddr = idx_q;
                rf_raddr = odd_idx;
                hold0_d  = rf_lout;
                hold1_d  = rf_rout;
                state_d  = S_WR0;
            end
            S_WR0: begin
                busy      = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = base_q + idx_ext;   // wraps modulo 2^DW
                mem_wdata = hold0_q;
                if (mem_ready) state_d = S_WR1;
            end
            S_WR1: begin
                busy      = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = base_q + odd_ext;
                mem_wdata = hold1_q;
                if (mem_ready) begin
                    if (last_pair) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + REG_AW'(2);
                        state_d = S_RD;
                    end
                end
            end
            R_LD: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = base_q + idx_ext;
                if (mem_ready) begin
                    hold0_d = mem_rdata;
                    state_d = RESTORE_SPLIT ? R_WRL : R_WR;
                end
            end
            R_WR, R_WRL, R_WRH: begin
                busy      = 1'b1;
                rf_laddr  = idx_q;
                rf_in     = hold0_q;
                rf_lwrite = (state_q != R_WRH);
                rf_hwrite = (state_q != R_WRL);
                if (state_q == R_WRL) begin
                    state_d = R_WRH;
                end else if (last_reg) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + REG_AW'(1);
                    state_d = R_LD;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            hold0_q <= '0;
            hold1_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            hold0_q <= hold0_d;
            hold1_q <= hold1_d;
        end
    end

endmodule

// File: tb/tb_rf_context_unit.sv
// Directed bench for rf_context_unit: u0 restores whole words, u1 restores
// low byte then high byte. Register files and memories are bench models.
module tb_rf_context_unit;

  logic clk = 1'b0;
  logic rst;

  logic        save_req [2];
  logic        restore_req [2];
  logic [15:0] base_addr [2];
  logic        busy [2];
  logic        done [2];
  logic [1:0]  rf_laddr [2];
  logic [1:0]  rf_raddr [2];
  logic [15:0] rf_lout [2];
  logic [15:0] rf_rout [2];
  logic [15:0] rf_in [2];
  logic        rf_lwrite [2];
  logic        rf_hwrite [2];
  logic [15:0] mem_addr [2];
  logic [15:0] mem_wdata [2];
  logic        mem_wr [2];
  logic        mem_rd [2];
  logic [15:0] mem_rdata [2];
  logic        mem_ready [2];

  logic [15:0] rf [2][4];
  logic [15:0] mem [2][65536];

  logic        pre_req = 1'b0;
  int          pre_k = 0;
  logic [15:0] pre_val [4];
  logic        stall_mode = 1'b0;
  logic [1:0]  wait_cnt = 2'd0;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];   // {mem_addr, mem_wdata} expected from u0 saves

  always #5 clk = ~clk;

  rf_context_unit #(.NUM_REGS(4), .REG_AW(2), .DW(16), .RESTORE_SPLIT(1'b0)) u0 (
    .clk(clk), .rst(rst), .save_req(save_req[0]), .restore_req(restore_req[0]),
    .base_addr(base_addr[0]), .busy(busy[0]), .done(done[0]),
    .rf_laddr(rf_laddr[0]), .rf_raddr(rf_raddr[0]), .rf_lout(rf_lout[0]),
    .rf_rout(rf_rout[0]), .rf_in(rf_in[0]), .rf_lwrite(rf_lwrite[0]),
    .rf_hwrite(rf_hwrite[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_wr(mem_wr[0]), .mem_rd(mem_rd[0]), .mem_rdata(mem_rdata[0]),
    .mem_ready(mem_ready[0])
  );

  rf_context_unit #(.NUM_REGS(4), .REG_AW(2), .DW(16), .RESTORE_SPLIT(1'b1)) u1 (
    .clk(clk), .rst(rst), .save_req(save_req[1]), .restore_req(restore_req[1]),
    .base_addr(base_addr[1]), .busy(busy[1]), .done(done[1]),
    .rf_laddr(rf_laddr[1]), .rf_raddr(rf_raddr[1]), .rf_lout(rf_lout[1]),
    .rf_rout(rf_rout[1]), .rf_in(rf_in[1]), .rf_lwrite(rf_lwrite[1]),
    .rf_hwrite(rf_hwrite[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_wr(mem_wr[1]), .mem_rd(mem_rd[1]), .mem_rdata(mem_rdata[1]),
    .mem_ready(mem_ready[1])
  );

  // Register file models: combinational reads, falling-edge byte writes.
  assign rf_lout[0]   = rf[0][rf_laddr[0]];
  assign rf_rout[0]   = rf[0][rf_raddr[0]];
  assign rf_lout[1]   = rf[1][rf_laddr[1]];
  assign rf_rout[1]   = rf[1][rf_raddr[1]];
  assign mem_rdata[0] = mem[0][mem_addr[0]];
  assign mem_rdata[1] = mem[1][mem_addr[1]];
  assign mem_ready[0] = !stall_mode || (wait_cnt == 2'd3);
  assign mem_ready[1] = 1'b1;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rf_lwrite[k]) rf[k][rf_laddr[k]][7:0]  <= rf_in[k][7:0];
      if (rf_hwrite[k]) rf[k][rf_laddr[k]][15:8] <= rf_in[k][15:8];
    end
    if (pre_req) begin
      for (int i = 0; i < 4; i++) rf[pre_k][i] <= pre_val[i];
    end
  end

  // Stalling memory: three not-ready cycles before each accepted access.
  always @(posedge clk) begin
    if (mem_rd[0] || mem_wr[0]) begin
      if (mem_ready[0]) wait_cnt <= 2'd0;
      else              wait_cnt <= wait_cnt + 2'd1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs(input int k);
    return {6'd0, busy[k], done[k], rf_laddr[k], rf_raddr[k], rf_in[k], rf_lwrite[k],
            rf_hwrite[k], mem_addr[k], mem_wdata[k], mem_wr[k], mem_rd[k]};
  endfunction

  // Memory-side scoreboard for u0, sampled mid-cycle.
  task automatic monitor();
    if (mem_wr[0]) begin
      chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        chk("wr_addr_data", {32'd0, mem_addr[0], mem_wdata[0]}, {32'd0, exp_q[0]});
        chk("wr_rd_exclusive", 64'(mem_rd[0]), 64'd0);
        if (mem_ready[0]) void'(exp_q.pop_front());
      end
    end
    if (mem_wr[1]) chk("u1_mem_wr", 64'(mem_wr[1]), 64'd0);
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input int k, input logic [15:0] v0, v1, v2, v3);
    pre_k = k;
    pre_val[0] = v0; pre_val[1] = v1; pre_val[2] = v2; pre_val[3] = v3;
    pre_req = 1'b1;
    tick();
    pre_req = 1'b0;
  endtask

  task automatic push4(input logic [15:0] base, input logic [15:0] v0, v1, v2, v3);
    exp_q.push_back({base,          v0});
    exp_q.push_back({base + 16'd1,  v1});
    exp_q.push_back({base + 16'd2,  v2});
    exp_q.push_back({base + 16'd3,  v3});
  endtask

  // which: 0 save, 1 restore, 2 both. Returns positioned in cycle 1.
  task automatic start(input int k, input int which, input logic [15:0] base);
    base_addr[k]   = base;
    save_req[k]    = (which != 1);
    restore_req[k] = (which != 0);
    tick();
    save_req[k]    = 1'b0;
    restore_req[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int start_c, input int limit,
                           output int cyc, output int busy_cnt, output logic strobe_seen);
    cyc = -1;
    busy_cnt = 0;
    strobe_seen = 1'b0;
    for (int c = start_c; c <= limit; c++) begin
      if (done[k]) begin
        cyc = c;
        break;
      end
      if (busy[k]) busy_cnt++;
      if (rf_lwrite[k] || rf_hwrite[k]) strobe_seen = 1'b1;
      tick();
    end
  endtask

  task automatic count_done(input int k, input int n, output int dn);
    dn = 0;
    for (int i = 0; i < n; i++) begin
      if (done[k]) dn++;
      tick();
    end
  endtask

  initial begin
    int   cyc;
    int   bc;
    int   dn;
    logic sb;

    for (int k = 0; k < 2; k++) begin
      save_req[k] = 1'b0;
      restore_req[k] = 1'b0;
      base_addr[k] = 16'h0;
    end
    rst = 1'b1;
    tick(); tick(); tick();
    chk("reset_outs_u0", outs(0), 64'd0);
    chk("reset_outs_u1", outs(1), 64'd0);
    rst = 1'b0;

    // Save with no stalls.
    preload(0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    push4(16'h0100, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    start(0, 0, 16'h0100);
    chk("save_busy_c1", 64'(busy[0]), 64'd1);
    wait_done(0, 1, 40, cyc, bc, sb);
    chk("save_done_cycle", 64'(cyc), 64'd7);
    chk("save_busy_cycles", 64'(bc), 64'd6);
    chk("save_no_strobes", 64'(sb), 64'd0);
    chk("save_done_busy_low", 64'(busy[0]), 64'd0);
    tick();
    chk("save_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("save_done_pulse", 64'(done[0]), 64'd0);

    // Whole-word restore.
    mem[0][16'h0200] = 16'hA0A1; mem[0][16'h0201] = 16'hB0B1;
    mem[0][16'h0202] = 16'hC0C1; mem[0][16'h0203] = 16'hD0D1;
    preload(0, 16'h0, 16'h0, 16'h0, 16'h0);
    start(0, 1, 16'h0200);
    wait_done(0, 1, 40, cyc, bc, sb);
    chk("restore_done_cycle", 64'(cyc), 64'd9);
    chk("restore_r0", 64'(rf[0][0]), 64'hA0A1);
    chk("restore_r1", 64'(rf[0][1]), 64'hB0B1);
    chk("restore_r2", 64'(rf[0][2]), 64'hC0C1);
    chk("restore_r3", 64'(rf[0][3]), 64'hD0D1);

    // Split restore on u1.
    mem[1][16'h0300] = 16'h1234; mem[1][16'h0301] = 16'h5566;
    mem[1][16'h0302] = 16'h7788; mem[1][16'h0303] = 16'h99AA;
    preload(1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    start(1, 1, 16'h0300);
    tick();
    chk("split_wrl_strobes", {62'd0, rf_lwrite[1], rf_hwrite[1]}, 64'b10);
    chk("split_wrl_addr_data", {46'd0, rf_laddr[1], rf_in[1]}, {46'd0, 2'd0, 16'h1234});
    tick();
    chk("split_after_low", 64'(rf[1][0]), 64'hFF34);
    chk("split_wrh_strobes", {62'd0, rf_lwrite[1], rf_hwrite[1]}, 64'b01);
    chk("split_wrh_addr_data", {46'd0, rf_laddr[1], rf_in[1]}, {46'd0, 2'd0, 16'h1234});
    tick();
    chk("split_after_high", 64'(rf[1][0]), 64'h1234);
    wait_done(1, 4, 40, cyc, bc, sb);
    chk("split_done_cycle", 64'(cyc), 64'd13);
    chk("split_r3", 64'(rf[1][3]), 64'h99AA);

    // Stalled save across the address wrap.
    stall_mode = 1'b1;
    preload(0, 16'h5A01, 16'h5A02, 16'h5A03, 16'h5A04);
    exp_q.push_back({16'hFFFE, 16'h5A01});
    exp_q.push_back({16'hFFFF, 16'h5A02});
    exp_q.push_back({16'h0000, 16'h5A03});
    exp_q.push_back({16'h0001, 16'h5A04});
    start(0, 0, 16'hFFFE);
    wait_done(0, 1, 80, cyc, bc, sb);
    chk("stall_done_cycle", 64'(cyc), 64'd19);
    tick();
    chk("stall_queue_drained", 64'(exp_q.size()), 64'd0);
    stall_mode = 1'b0;

    // Both requests together: save wins.
    preload(0, 16'h0AA0, 16'h0BB0, 16'h0CC0, 16'h0DD0);
    for (int i = 0; i < 4; i++) mem[0][16'h0400 + 16'(i)] = 16'hEEEE;
    push4(16'h0400, 16'h0AA0, 16'h0BB0, 16'h0CC0, 16'h0DD0);
    start(0, 2, 16'h0400);
    wait_done(0, 1, 40, cyc, bc, sb);
    chk("arb_done_cycle", 64'(cyc), 64'd7);
    chk("arb_no_strobes", 64'(sb), 64'd0);
    tick();
    chk("arb_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("arb_r0_kept", 64'(rf[0][0]), 64'h0AA0);

    // Restore pulsed mid-save and during done: both ignored.
    push4(16'h0500, 16'h0AA0, 16'h0BB0, 16'h0CC0, 16'h0DD0);
    start(0, 0, 16'h0500);
    tick(); tick();
    restore_req[0] = 1'b1;
    tick();
    restore_req[0] = 1'b0;
    wait_done(0, 4, 40, cyc, bc, sb);
    chk("midsave_done_cycle", 64'(cyc), 64'd7);
    restore_req[0] = 1'b1;
    tick();
    restore_req[0] = 1'b0;
    chk("done_req_ignored", 64'(busy[0]), 64'd0);
    count_done(0, 12, dn);
    chk("midsave_single_done", 64'(dn), 64'd0);
    chk("midsave_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("midsave_r3_kept", 64'(rf[0][3]), 64'h0DD0);

    // Reset during the second whole-word write.
    mem[0][16'h0600] = 16'h1010; mem[0][16'h0601] = 16'h2020;
    mem[0][16'h0602] = 16'h3030; mem[0][16'h0603] = 16'h4040;
    preload(0, 16'h0, 16'h0, 16'h7777, 16'h8888);
    start(0, 1, 16'h0600);
    tick(); tick(); tick();
    chk("rst_second_wr", {44'd0, rf_laddr[0], rf_lwrite[0], rf_hwrite[0], rf_in[0]},
        {44'd0, 2'd1, 1'b1, 1'b1, 16'h2020});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_outs_zero", outs(0), 64'd0);
    count_done(0, 10, dn);
    chk("rst_no_done", 64'(dn), 64'd0);
    chk("rst_r0", 64'(rf[0][0]), 64'h1010);
    chk("rst_r1", 64'(rf[0][1]), 64'h2020);
    chk("rst_r2_kept", 64'(rf[0][2]), 64'h7777);
    chk("rst_r3_kept", 64'(rf[0][3]), 64'h8888);

    push4(16'h0700, 16'h1010, 16'h2020, 16'h7777, 16'h8888);
    start(0, 0, 16'h0700);
    wait_done(0, 1, 40, cyc, bc, sb);
    chk("post_rst_done_cycle", 64'(cyc), 64'd7);
    tick();
    chk("post_rst_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
